uart_program_loader: RTL

Boot-time loader sitting upstream of the processor datapath. It collects bytes from the UART receiver, packs every four bytes into a 32-bit little-endian instruction, and writes each one into instruction memory at consecutive word addresses. While loading it holds the processor stalled; once a halt word arrives or memory is full, it releases the processor to run.

---
 rtl/uart_program_loader_if.sv | 30 +++
 rtl/uart_program_loader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader_if.sv
// Byte-input, instruction-memory-write and status signals of the boot-time program loader.
// The loader uses the slave modport; the UART side / test environment uses master.
interface uart_program_loader_if #(
    parameter int MEM_WORDS = 64
);
    localparam int WL_W = $clog2(MEM_WORDS + 1);

    logic [7:0]      rx_data;
    logic            rx_done;
    logic            start;
    logic            imem_wr_en;
    logic [31:0]     imem_addr;
    logic [31:0]     imem_wdata;
    logic            cpu_hold;
    logic            load_done;
    logic [WL_W-1:0] words_loaded;
    logic            frame_err;

    modport master (
        output rx_data, rx_done, start,
        input  imem_wr_en, imem_addr, imem_wdata, cpu_hold, load_done,
               words_loaded, frame_err
    );

    modport slave (
        input  rx_data, rx_done, start,
        output imem_wr_en, imem_addr, imem_wdata, cpu_hold, load_done,
               words_loaded, frame_err
    );
endinterface

// File: rtl/uart_program_loader.sv
// Packs UART bytes little-endian into 32-bit words, writes them to instruction memory
// and keeps the processor held until a halt word arrives or memory is full.
module uart_program_loader #(
    parameter int          MEM_WORDS   = 64,
    parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYC = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_program_loader_if.slave  bus
);
    localparam int WL_W = $clog2(MEM_WORDS + 1);
    localparam int TC_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WL_W-1:0] WORDS_FULL = WL_W'(MEM_WORDS);
    localparam logic [TC_W-1:0] TC_LAST    = TC_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_r;
    logic [1:0]      byte_idx_r;
    logic [TC_W-1:0] tmo_cnt_r;
    logic [31:0]     buf_r;
    logic            wr_en_r;
    logic [31:0]     addr_r;
    logic [31:0]     wdata_r;
    logic            hold_r;
    logic            done_r;
    logic [WL_W-1:0] words_r;
    logic            ferr_r;

    logic [WL_W-1:0] words_inc_s;
    logic            mem_full_s;
    logic            last_word_s;
    logic            tmo_hit_s;

    // Place one received byte into lane idx of the collection buffer.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r        = word;
        endcase
        return r;
    endfunction

    // Decode end-of-load and timeout conditions from the current registered state.
    always_comb begin
        words_inc_s = words_r + WL_W'(1);
        mem_full_s  = (words_inc_s == WORDS_FULL);
        last_word_s = (wdata_r == HALT_WORD) || mem_full_s;
        tmo_hit_s   = (tmo_cnt_r == TC_LAST);
    end

    // Loader FSM: byte collection, one-cycle memory write, and released state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_LOAD;
            byte_idx_r <= 2'd0;
            tmo_cnt_r  <= '0;
            buf_r      <= 32'd0;
            wr_en_r    <= 1'b0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            hold_r     <= 1'b1;
            done_r     <= 1'b0;
            words_r    <= '0;
            ferr_r     <= 1'b0;
        end else if (bus.start) begin
            // Re-arm wins over any byte strobe arriving in the same cycle.
            state_r    <= ST_LOAD;
            byte_idx_r <= 2'd0;
            tmo_cnt_r  <= '0;
            wr_en_r    <= 1'b0;
            addr_r     <= 32'd0;
            hold_r     <= 1'b1;
            done_r     <= 1'b0;
            words_r    <= '0;
            ferr_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    wr_en_r <= 1'b0;
                    if (bus.rx_done) begin
                        buf_r     <= insert_byte(buf_r, byte_idx_r, bus.rx_data);
                        tmo_cnt_r <= '0;
                        if (byte_idx_r == 2'd3) begin
                            wdata_r    <= {bus.rx_data, buf_r[23:0]};
                            wr_en_r    <= 1'b1;
                            byte_idx_r <= 2'd0;
                            state_r    <= ST_WRITE;
                        end else begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end else if (byte_idx_r != 2'd0) begin
                        if (tmo_hit_s) begin
                            byte_idx_r <= 2'd0;
                            tmo_cnt_r  <= '0;
                            ferr_r     <= 1'b1;
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r + TC_W'(1);
                        end
                    end else begin
                        tmo_cnt_r <= '0;
                    end
                end
                ST_WRITE: begin
                    wr_en_r   <= 1'b0;
                    words_r   <= words_inc_s;
                    tmo_cnt_r <= '0;
                    // The last slot keeps its address so imem_addr never runs past memory.
                    if (mem_full_s) begin
                        addr_r <= addr_r;
                    end else begin
                        addr_r <= addr_r + 32'd4;
                    end
                    if (last_word_s) begin
                        state_r    <= ST_DONE;
                        byte_idx_r <= 2'd0;
                        hold_r     <= 1'b0;
                        done_r     <= 1'b1;
                    end else if (bus.rx_done) begin
                        state_r    <= ST_LOAD;
                        buf_r      <= insert_byte(buf_r, 2'd0, bus.rx_data);
                        byte_idx_r <= 2'd1;
                    end else begin
                        state_r    <= ST_LOAD;
                        byte_idx_r <= 2'd0;
                    end
                end
                ST_DONE: begin
                    wr_en_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_LOAD;
                    byte_idx_r <= 2'd0;
                    tmo_cnt_r  <= '0;
                    wr_en_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_wr_en   = wr_en_r;
    assign bus.imem_addr    = addr_r;
    assign bus.imem_wdata   = wdata_r;
    assign bus.cpu_hold     = hold_r;
    assign bus.load_done    = done_r;
    assign bus.words_loaded = words_r;
    assign bus.frame_err    = ferr_r;
endmodule
